// File: rtl/reg_dump_uart_if.sv
// Handshake and data bundle between a debug host and the register-dump UART.
// The host drives start and the live register view; the UART returns the serial line and status.
interface reg_dump_uart_if;
    logic        start;
    logic [31:0] dbg_regs [0:31];
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output start, dbg_regs, input tx, busy, done);
    modport slave  (input start, dbg_regs, output tx, busy, done);
endinterface

// File: rtl/reg_dump_uart.sv
// Streams a snapshot of the 32-entry register file over an 8N1 UART as a
// 129-byte frame: SYNC_BYTE followed by x0..x31, each sent MSB-first.
module reg_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    reg_dump_uart_if.slave  bus
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      LAST_BYTE = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt,  w_clk_cnt_nxt;
    logic [2:0]       r_bit_idx,  w_bit_idx_nxt;
    logic [7:0]       r_byte_idx, w_byte_idx_nxt;
    logic             r_done,     w_done_nxt;
    logic [31:0]      r_snap [0:31];

    logic             w_accept;
    logic             w_bit_end;
    logic [6:0]       w_payload_idx;
    logic [31:0]      w_cur_word;
    logic [7:0]       w_cur_byte;
    logic             w_tx;

    assign w_accept      = (r_state == IDLE) && bus.start;
    assign w_bit_end     = (r_clk_cnt == CNT_LAST);
    // Byte 0 is the header, so payload byte k lives at frame index k+1.
    assign w_payload_idx = 7'(r_byte_idx - 8'd1);
    assign w_cur_word    = (w_payload_idx[6:2] == 5'd0) ? 32'h0 : r_snap[w_payload_idx[6:2]];

    always_comb begin
        w_cur_byte = SYNC_BYTE;
        if (r_byte_idx != 8'd0) begin
            case (w_payload_idx[1:0])
                2'd0:    w_cur_byte = w_cur_word[31:24];
                2'd1:    w_cur_byte = w_cur_word[23:16];
                2'd2:    w_cur_byte = w_cur_word[15:8];
                default: w_cur_byte = w_cur_word[7:0];
            endcase
        end
    end

    // NOTE: snapshot storage carries no reset; its contents only matter after an accepted start reloads it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap <= bus.dbg_regs;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_clk_cnt_nxt  = w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_done_nxt     = 1'b0;
        w_tx           = 1'b1;

        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                if (bus.start) begin
                    w_state_nxt    = START_BIT;
                    w_bit_idx_nxt  = '0;
                    w_byte_idx_nxt = '0;
                end
            end
            START_BIT: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt   = DATA_BITS;
                    w_bit_idx_nxt = '0;
                end
            end
            DATA_BITS: begin
                w_tx = w_cur_byte[r_bit_idx];
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP_BIT;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    if (r_byte_idx < LAST_BYTE) begin
                        w_state_nxt    = START_BIT;
                        w_byte_idx_nxt = r_byte_idx + 8'd1;
                    end else begin
                        w_state_nxt    = IDLE;
                        w_byte_idx_nxt = '0;
                        w_done_nxt     = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.tx   = w_tx;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;

endmodule

// File: doc/reg_dump_uart.md
REG_DUMP_UART -- requirements
Module: reg_dump_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame header byte sent before the register data.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  meaning a request to dump the register file, sampled on the rising edge of clk.
REQ-006 SHALL have port dbg_regs  input  32x32 (unpacked [0:31] of [31:0])  meaning the live architectural register values; entry 0 reads as zero.
REQ-007 SHALL have port tx  output  1  meaning the UART serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  meaning a frame is in progress.
REQ-009 SHALL have port done  output  1  meaning a one-cycle pulse when a frame completes.

Function
REQ-010 SHALL accept start only on an edge where busy=0; while busy=1, start SHALL be ignored and SHALL NOT be queued.
REQ-011 SHALL, on acceptance, snapshot all 32 dbg_regs entries into internal storage in that same edge; later dbg_regs changes SHALL NOT affect the frame in progress.
REQ-012 SHALL transmit a frame of 129 bytes: SYNC_BYTE, then x0..x31, each register sent as 4 bytes, most-significant byte first.
REQ-013 SHALL send each byte as: start bit (0), 8 data bits LSB first, stop bit (1), with each bit held on tx for exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send bytes back-to-back, with the next start bit immediately after the previous stop bit and no idle bits inside a frame.
REQ-015 SHALL implement FSM states IDLE -> START_BIT -> DATA_BITS -> STOP_BIT; from STOP_BIT go to START_BIT if the byte index is < 128, else go to IDLE.
REQ-016 SHALL, in the cycle after acceptance, drive busy=1 and tx=0 (the first start bit).
REQ-017 SHALL hold busy=1 for exactly 129*10*CLKS_PER_BIT cycles per frame.
REQ-018 SHALL, in the cycle after the final stop bit ends, drive busy=0 and done=1 for exactly one cycle; tx SHALL be 1.
REQ-019 SHALL accept a start asserted in the same cycle done=1, since busy=0 in that cycle; the new frame begins in the following cycle.
REQ-020 SHALL keep tx=1 whenever in IDLE.
REQ-021 SHALL use a bit-period counter wide enough for CLKS_PER_BIT-1 that wraps to 0 at the end of each bit, a 3-bit data-bit index, and an 8-bit byte index (0..128) that never wraps within a frame.
REQ-022 SHALL transmit x0 as 32'h0 regardless of the value on dbg_regs[0].

Reset
REQ-023 SHALL, while reset=0, asynchronously force tx=1, busy=0, done=0, state=IDLE, and all counters to 0.
REQ-024 SHALL treat reset asserted mid-frame as an abort: the frame is truncated, no done pulse occurs, and tx returns to 1 immediately.
REQ-025 SHALL NOT require the snapshot storage to be cleared by reset.
REQ-026 SHALL, after reset is released, remain in IDLE until the first accepted start.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL cover basic frame: dbg_regs[i]=32'h01000000*i+i, pulse start -> decoded bytes A5, 00 00 00 00, 01 00 00 01, ..., 1F 00 00 1F; busy high 5160 cycles; one done pulse.
REQ-028 SHALL cover bit timing: first byte A5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles.
REQ-029 SHALL cover snapshot: change every dbg_regs entry to 32'hFFFFFFFF one cycle after start -> frame still carries the original values.
REQ-030 SHALL cover ignored start: pulse start at cycles 100 and 3000 of a frame -> exactly one 129-byte frame and one done pulse.
REQ-031 SHALL cover back-to-back: hold start high continuously -> second A5 start bit begins in the cycle after done, with no idle gap.
REQ-032 SHALL cover reset mid-frame: assert reset during byte 50 -> tx=1 and busy=0 in the same cycle; no done pulse; a fresh start then yields a complete, correct frame.
